// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Receive-side timing recovery for an external VGA h_sync/v_sync pair.
//   Measures line and frame periods, locks once the timing is stable, and
//   regenerates pixel/line counters and a display window aligned to the
//   incoming video (fixed 3-clock offset from the pins).
//
// Ports
//   clk_in      in   pixel clock, rising edge
//   reset       in   synchronous, active-low
//   h_sync_in   in   asynchronous horizontal sync pin
//   v_sync_in   in   asynchronous vertical sync pin
//   h_count     out  regenerated pixel counter (0 while searching)
//   v_count     out  regenerated line counter (0 while searching)
//   display_en  out  active-window flag, only while locked
//   frame_start out  one-cycle pulse per v_sync leading edge
//   locked      out  timing stable
//   h_total     out  last measured clocks per line
//   v_total     out  last measured lines per frame
//   sync_err    out  one-cycle pulse on mismatch or missing sync
module vga_sync_decoder #(
    parameter int SYNC_POL    = 1,
    parameter int H_START     = 384,
    parameter int H_ACTIVE    = 1280,
    parameter int V_START     = 38,
    parameter int V_ACTIVE    = 960,
    parameter int LOCK_FRAMES = 2,
    parameter int H_TOL       = 1
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    output logic [11:0] h_count,
    output logic [11:0] v_count,
    output logic        display_en,
    output logic        frame_start,
    output logic        locked,
    output logic [11:0] h_total,
    output logic [11:0] v_total,
    output logic        sync_err
);
    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    localparam logic [11:0] CNT_MAX = '1;
    localparam logic [11:0] CNT_PRE = 12'hFFE;
    localparam logic [12:0] H_BEG   = 13'(H_START);
    localparam logic [12:0] H_END   = 13'(H_START + H_ACTIVE);
    localparam logic [12:0] V_BEG   = 13'(V_START);
    localparam logic [12:0] V_END   = 13'(V_START + V_ACTIVE);
    localparam logic [11:0] TOL     = 12'(H_TOL);
    localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);
    localparam logic        INV     = (SYNC_POL == 0) ? 1'b1 : 1'b0;

    // Synchronizer flops hold the polarity-normalised level, so a cleared
    // flop always means "sync inactive".
    logic        h_meta_q, h_sync_q, h_prev_q;
    logic        v_meta_q, v_sync_q, v_prev_q;
    logic        h_edge, v_edge, v_clr;
    logic [11:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [11:0] h_meas, v_meas, h_diff;
    logic [11:0] h_total_q, v_total_q;
    logic        v_pend_q, v_pend_d;
    logic        line_bad_q, line_bad_d;
    logic        bad_line, frame_ok, h_tmo, v_tmo, in_win;
    state_t      state_q, state_d;
    logic [3:0]  match_q, match_d;
    logic        started_q, started_d, ref_q, ref_d;
    logic        err_q, err_d, disp_q, fs_q;

    always_comb begin
        h_edge   = h_sync_q & ~h_prev_q;
        v_edge   = v_sync_q & ~v_prev_q;
        // A v edge is held until the next h edge so v_count clears on a line boundary.
        v_clr    = h_edge & (v_edge | v_pend_q);
        h_meas   = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + 12'd1;
        v_meas   = (vcnt_q == CNT_MAX) ? CNT_MAX : vcnt_q + 12'd1;
        h_diff   = (h_meas >= h_total_q) ? h_meas - h_total_q : h_total_q - h_meas;
        bad_line = h_edge & (h_diff > TOL);
        frame_ok = (v_meas == v_total_q) & ~line_bad_q & ~bad_line;
        // Fire once, on the step into saturation.
        h_tmo    = ~h_edge & (hcnt_q == CNT_PRE);
        v_tmo    = h_edge & ~v_clr & (vcnt_q == CNT_PRE);
        hcnt_d   = h_edge ? '0 : h_meas;
        vcnt_d   = v_clr ? '0 : (h_edge ? v_meas : vcnt_q);
        v_pend_d = h_edge ? 1'b0 : (v_pend_q | v_edge);
        line_bad_d = v_clr ? 1'b0 : (line_bad_q | bad_line);
        in_win   = ({1'b0, hcnt_q} >= H_BEG) & ({1'b0, hcnt_q} < H_END) &
                   ({1'b0, vcnt_q} >= V_BEG) & ({1'b0, vcnt_q} < V_END);
    end

    // MEASURE skips two frame boundaries before comparing: the first opens
    // a full frame (unless the entry edge already cleared v), the second
    // closes the reference frame whose v_total becomes the comparison value.
    always_comb begin
        state_d   = state_q;
        match_d   = match_q;
        started_d = started_q;
        ref_d     = ref_q;
        err_d     = 1'b0;
        case (state_q)
            SEARCH: begin
                if (v_edge) begin
                    state_d   = MEASURE;
                    match_d   = '0;
                    started_d = v_clr;
                    ref_d     = 1'b0;
                end
            end
            MEASURE: begin
                if (v_clr) begin
                    if (!started_q) begin
                        started_d = 1'b1;
                    end else if (!ref_q) begin
                        ref_d = 1'b1;
                    end else if (frame_ok) begin
                        match_d = match_q + 4'd1;
                        if (match_d == LOCK_N) state_d = LOCKED;
                    end else begin
                        match_d = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (bad_line || (v_clr && (v_meas != v_total_q))) begin
                    err_d   = 1'b1;
                    state_d = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase
        if (h_tmo || v_tmo) begin
            err_d   = 1'b1;
            state_d = SEARCH;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            h_meta_q   <= 1'b0;
            h_sync_q   <= 1'b0;
            h_prev_q   <= 1'b0;
            v_meta_q   <= 1'b0;
            v_sync_q   <= 1'b0;
            v_prev_q   <= 1'b0;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            h_total_q  <= '0;
            v_total_q  <= '0;
            v_pend_q   <= 1'b0;
            line_bad_q <= 1'b0;
            state_q    <= SEARCH;
            match_q    <= '0;
            started_q  <= 1'b0;
            ref_q      <= 1'b0;
            err_q      <= 1'b0;
            disp_q     <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            h_meta_q   <= h_sync_in ^ INV;
            h_sync_q   <= h_meta_q;
            h_prev_q   <= h_sync_q;
            v_meta_q   <= v_sync_in ^ INV;
            v_sync_q   <= v_meta_q;
            v_prev_q   <= v_sync_q;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            if (h_edge) h_total_q <= h_meas;
            if (v_clr)  v_total_q <= v_meas;
            v_pend_q   <= v_pend_d;
            line_bad_q <= line_bad_d;
            state_q    <= state_d;
            match_q    <= match_d;
            started_q  <= started_d;
            ref_q      <= ref_d;
            err_q      <= err_d;
            // Gated by the next state so the window drops with lock.
            disp_q     <= (state_d == LOCKED) & in_win;
            fs_q       <= v_edge;
        end
    end

    assign h_count     = (state_q == SEARCH) ? '0 : hcnt_q;
    assign v_count     = (state_q == SEARCH) ? '0 : vcnt_q;
    assign display_en  = disp_q;
    assign frame_start = fs_q;
    assign locked      = (state_q == LOCKED);
    assign h_total     = h_total_q;
    assign v_total     = v_total_q;
    assign sync_err    = err_q;
endmodule
